// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_mode_sequencer
//  Description : BtnU-driven LED pattern controller. Debounces the button and
//                cycles OFF / SOLID / BLINK_SLOW / BLINK_FAST / CHASE, all
//                paced by a shared prescaler tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
    parameter int unsigned TICK_MAX     = 20_000_000 - 1,
    parameter int unsigned DEBOUNCE_MAX = 2_000_000 - 1,
    parameter int unsigned SLOW_TICKS   = 5,
    parameter int unsigned FAST_TICKS   = 1,
    parameter int unsigned NUM_LEDS     = 8
) (
    input  logic                clk_200mhz,
    input  logic                reset,
    input  logic                btn_mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic [2:0]          mode
);

    localparam int unsigned c_PRE_W = $clog2(TICK_MAX + 1);
    localparam int unsigned c_DB_W  = $clog2(DEBOUNCE_MAX + 1);
    localparam int unsigned c_PH_W  = $clog2(SLOW_TICKS + 1);
    localparam int unsigned c_POS_W = $clog2(NUM_LEDS);

    localparam logic [c_PRE_W-1:0]  c_TICK_LAST = c_PRE_W'(TICK_MAX);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_MAX);
    localparam logic [c_PH_W-1:0]   c_SLOW_LAST = c_PH_W'(SLOW_TICKS - 1);
    localparam logic [c_PH_W-1:0]   c_FAST_LAST = c_PH_W'(FAST_TICKS - 1);
    localparam logic [c_POS_W-1:0]  c_POS_LAST  = c_POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] c_LED_ONE   = NUM_LEDS'(1);

    localparam logic [2:0] c_MODE_OFF        = 3'd0;
    localparam logic [2:0] c_MODE_SOLID      = 3'd1;
    localparam logic [2:0] c_MODE_BLINK_SLOW = 3'd2;
    localparam logic [2:0] c_MODE_BLINK_FAST = 3'd3;
    localparam logic [2:0] c_MODE_CHASE      = 3'd4;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_db;
    logic                r_db_q;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_PRE_W-1:0]  r_prescale;
    logic [c_PH_W-1:0]   r_phase;
    logic                r_blink;
    logic [c_POS_W-1:0]  r_chase_pos;
    logic [2:0]          r_mode;
    logic [NUM_LEDS-1:0] r_leds;

    logic                w_rise;
    logic                w_tick;
    logic                w_wrap;
    logic [c_PH_W-1:0]   w_phase_last;
    logic [2:0]          w_mode_next;
    logic [NUM_LEDS-1:0] w_leds_next;

    // Synchronizer and debounce: db only follows s2 after it has differed
    // for DEBOUNCE_MAX+1 consecutive cycles.
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_q   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn_mode;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            if (r_sync2 != r_db) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_rise = r_db & ~r_db_q;

    // A mode advance suppresses the tick so the new mode starts from a clean slate.
    assign w_tick = (r_prescale == c_TICK_LAST) && !w_rise;

    always_comb begin
        w_phase_last = c_FAST_LAST;
        if (r_mode == c_MODE_BLINK_SLOW) begin
            w_phase_last = c_SLOW_LAST;
        end
    end

    assign w_wrap = w_tick && (r_phase == w_phase_last);

    always_comb begin
        w_mode_next = c_MODE_SOLID;
        case (r_mode)
            c_MODE_OFF:        w_mode_next = c_MODE_SOLID;
            c_MODE_SOLID:      w_mode_next = c_MODE_BLINK_SLOW;
            c_MODE_BLINK_SLOW: w_mode_next = c_MODE_BLINK_FAST;
            c_MODE_BLINK_FAST: w_mode_next = c_MODE_CHASE;
            c_MODE_CHASE:      w_mode_next = c_MODE_OFF;
            default:           w_mode_next = c_MODE_SOLID;
        endcase
    end

    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_mode      <= c_MODE_OFF;
            r_prescale  <= '0;
            r_phase     <= '0;
            r_blink     <= 1'b0;
            r_chase_pos <= '0;
        end else if (w_rise) begin
            r_mode      <= w_mode_next;
            r_prescale  <= '0;
            r_phase     <= '0;
            r_blink     <= 1'b0;
            r_chase_pos <= '0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_wrap) begin
                r_phase <= '0;
                if ((r_mode == c_MODE_BLINK_SLOW) || (r_mode == c_MODE_BLINK_FAST)) begin
                    r_blink <= ~r_blink;
                end
                if (r_mode == c_MODE_CHASE) begin
                    r_chase_pos <= (r_chase_pos == c_POS_LAST) ? '0 : r_chase_pos + 1'b1;
                end
            end else if (w_tick) begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    always_comb begin
        w_leds_next = '0;
        case (r_mode)
            c_MODE_SOLID:      w_leds_next = '1;
            c_MODE_BLINK_SLOW: w_leds_next = {NUM_LEDS{r_blink}};
            c_MODE_BLINK_FAST: w_leds_next = {NUM_LEDS{r_blink}};
            c_MODE_CHASE:      w_leds_next = c_LED_ONE << r_chase_pos;
            default:           w_leds_next = '0;
        endcase
    end

    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds_next;
        end
    end

    assign leds = r_leds;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_mode_sequencer
//  Description : Scoreboard bench for led_mode_sequencer with short sim timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

    logic       clk_200mhz = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic [7:0] leds;
    logic [2:0] mode;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         at;
        logic [7:0] leds;
        logic [2:0] mode;
        bit         cl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    led_mode_sequencer #(
        .TICK_MAX     (9),
        .DEBOUNCE_MAX (3),
        .SLOW_TICKS   (2),
        .FAST_TICKS   (1),
        .NUM_LEDS     (8)
    ) dut (
        .clk_200mhz (clk_200mhz),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .leds       (leds),
        .mode       (mode)
    );

    always #5 clk_200mhz = ~clk_200mhz;

    always @(posedge clk_200mhz) cyc <= cyc + 1;

    task automatic wait_edge();
        @(posedge clk_200mhz);
        #1;
    endtask

    function automatic void push(input int at, input logic [7:0] l, input logic [2:0] m,
                                 input bit cl, input string tag);
        exp_t x;
        x.at   = at;
        x.leds = l;
        x.mode = m;
        x.cl   = cl;
        x.tag  = tag;
        sb.push_back(x);
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        btn_mode = 1'b0;
        repeat (3) wait_edge();
        reset = 1'b0;
        wait_edge();
    endtask

    task automatic test_reset();
        int t0;
        reset    = 1'b1;
        btn_mode = 1'b1;
        t0       = cyc;
        for (int i = 1; i <= 5; i++) push(t0 + i, 8'h00, 3'd0, 1, "reset_hold");
        push(t0 + 11, 8'h00, 3'd0, 1, "held_pre");
        push(t0 + 12, 8'h00, 3'd1, 1, "held_mode");
        push(t0 + 13, 8'hFF, 3'd1, 1, "held_leds");
        for (int i = 0; i < 15; i++) begin
            reset    = (i < 5);
            btn_mode = (i < 13);
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL reset_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_press();
        int t0;
        do_reset();
        t0 = cyc;
        push(t0 + 6,  8'h00, 3'd0, 1, "press_pre");
        push(t0 + 7,  8'h00, 3'd1, 1, "press_mode");
        push(t0 + 8,  8'hFF, 3'd1, 1, "press_leds");
        push(t0 + 30, 8'hFF, 3'd1, 1, "release_a");
        push(t0 + 35, 8'hFF, 3'd1, 1, "release_b");
        for (int i = 0; i < 35; i++) begin
            btn_mode = (i < 20);
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL press_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        int t0;
        do_reset();
        t0 = cyc;
        for (int i = 1; i <= 25; i++) push(t0 + i, 8'h00, 3'd0, 1, "glitch");
        for (int i = 0; i < 25; i++) begin
            btn_mode = (i == 0) || (i >= 6 && i < 9);
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL glitch_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mode_cycle();
        int t0;
        int p;
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            p = t0 + 16 * k;
            push(p + 6, 8'h00, 3'(k), 0, "cycle_pre");
            push(p + 7, 8'h00, 3'((k + 1) % 5), 0, "cycle_mode");
            if (k == 0) push(p + 8, 8'hFF, 3'd1, 1, "cycle_solid");
            if (k == 4) push(p + 8, 8'h00, 3'd0, 1, "cycle_off");
        end
        for (int i = 0; i < 80; i++) begin
            btn_mode = (i % 16) < 8;
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL cycle_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_blink();
        int t0;
        int en;
        int en2;
        do_reset();
        t0  = cyc;
        en  = t0 + 23;
        en2 = t0 + 77;
        push(en,      8'hFF, 3'd2, 1, "slow_entry");
        push(en + 1,  8'h00, 3'd2, 1, "slow_dark_a");
        push(en + 20, 8'h00, 3'd2, 1, "slow_dark_b");
        push(en + 21, 8'hFF, 3'd2, 1, "slow_lit_a");
        push(en + 40, 8'hFF, 3'd2, 1, "slow_lit_b");
        push(en + 41, 8'h00, 3'd2, 1, "slow_dark_c");
        push(en + 45, 8'h00, 3'd2, 1, "slow_dark_d");
        push(en2,      8'h00, 3'd3, 1, "fast_entry");
        push(en2 + 1,  8'h00, 3'd3, 1, "fast_dark_a");
        push(en2 + 10, 8'h00, 3'd3, 1, "fast_dark_b");
        push(en2 + 11, 8'hFF, 3'd3, 1, "fast_lit_a");
        push(en2 + 20, 8'hFF, 3'd3, 1, "fast_lit_b");
        push(en2 + 21, 8'h00, 3'd3, 1, "fast_dark_c");
        push(en2 + 30, 8'h00, 3'd3, 1, "fast_dark_d");
        for (int i = 0; i < 110; i++) begin
            btn_mode = (i < 8) || (i >= 16 && i < 24) || (i >= 70 && i < 78);
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL blink_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_chase();
        int t0;
        int en;
        int en2;
        logic [7:0] oh;
        do_reset();
        t0  = cyc;
        en  = t0 + 55;
        en2 = t0 + 219;
        push(en, 8'h00, 3'd4, 0, "chase_entry");
        for (int j = 0; j <= 8; j++) begin
            oh = 8'h01 << (j % 8);
            push(en + 1 + 10 * j,  oh, 3'd4, 1, "chase_step_a");
            push(en + 10 + 10 * j, oh, 3'd4, 1, "chase_step_b");
        end
        // Exit lands on a tick cycle: the advance must win.
        push(t0 + 155, 8'h02, 3'd0, 1, "chase_exit");
        push(t0 + 156, 8'h00, 3'd0, 1, "chase_off");
        push(en2,      8'h00, 3'd4, 0, "rechase_entry");
        push(en2 + 1,  8'h01, 3'd4, 1, "rechase_clear");
        push(en2 + 10, 8'h01, 3'd4, 1, "rechase_hold");
        push(en2 + 11, 8'h02, 3'd4, 1, "rechase_step");
        push(t0 + 234, 8'h02, 3'd4, 1, "prereset");
        push(t0 + 235, 8'h00, 3'd0, 1, "midreset");
        for (int i = 0; i < 240; i++) begin
            btn_mode = ((i < 64) && ((i % 16) < 8)) || (i >= 148 && i < 156) ||
                       (i >= 164 && i < 228 && (((i - 164) % 16) < 8));
            reset    = (i >= 234 && i < 237);
            wait_edge();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at != cyc || mode !== e.mode || (e.cl && leds !== e.leds)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got mode=%0d leds=%h, want mode=%0d leds=%h (due %0d)",
                             e.tag, cyc, mode, leds, e.mode, e.leds, e.at);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL chase_leftover: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b1;
        test_reset();
        test_press();
        test_glitch();
        test_mode_cycle();
        test_blink();
        test_chase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
